// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The master modport is the fetch/decode side; the slave modport is the queue itself.
interface instr_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] next_instr;
  logic [PC_W-1:0]  next_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] instr;
  logic [PC_W-1:0]  pc;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid,
    output next_instr,
    output next_pc,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  instr,
    input  pc,
    input  count
  );

  modport slave (
    input  in_valid,
    input  next_instr,
    input  next_pc,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output instr,
    output pc,
    output count
  );

endinterface

// File: rtl/instr_queue.sv
// DEPTH-entry instruction/PC FIFO between fetch and decode.
// Flush beats push and pop. An empty queue presents NOP/0 on its outputs, and input never
// bypasses to output in the same cycle.
module instr_queue #(
  parameter int unsigned     WIDTH = 32,
  parameter int unsigned     PC_W  = 32,
  parameter int unsigned     DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP  = '0,
  parameter int unsigned     CNT_W = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  instr_queue_if.slave q
);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = q.in_valid && !full && !q.flush;
  assign pop   = q.out_ready && !empty && !q.flush;

  // Next-state for the pointers and the occupancy count; flush returns everything to zero.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; deliberately not reset, since the count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= q.next_instr;
      pc_mem[wr_ptr_q]    <= q.next_pc;
    end
  end

  // Handshake and count come from the count register alone; the head read is masked when empty.
  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.count     = count_q;
  assign q.instr     = empty ? NOP : instr_mem[rd_ptr_q];
  assign q.pc        = empty ? '0  : pc_mem[rd_ptr_q];

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction buffer between the fetch stage and the decode/control stage of the CPU. It generalises the single enable-gated instruction register into a DEPTH-entry FIFO carrying an instruction word and its PC, with a valid/ready handshake on both sides and a synchronous flush for branches and jumps. It lets fetch run ahead of a stalled decode without losing words, and it presents a defined NOP when nothing is buffered.

## Interface
- WIDTH, 32: instruction word width.
- PC_W, 32: width of the PC tag stored with each word.
- DEPTH, 4: number of entries; power of two, at least 2.
- NOP, 0: value driven on `instr` while the queue is empty.
- CNT_W, $clog2(DEPTH+1): width of `count`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch is presenting a word.
- in_ready  out  1  queue can accept a word; equals !full.
- next_instr  in  WIDTH  instruction word to enqueue.
- next_pc  in  PC_W  PC of `next_instr`.
- out_valid  out  1  head entry is valid; equals !empty.
- out_ready  in  1  decode consumes the head this cycle.
- instr  out  WIDTH  head instruction, or NOP when empty.
- pc  out  PC_W  head PC, or 0 when empty.
- flush  in  1  discard all entries (redirect).
- count  out  CNT_W  number of valid entries, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry array with read pointer `rd_ptr` and write pointer `wr_ptr`, each log2(DEPTH) bits. Both pointers wrap modulo DEPTH. `count` is kept as a separate register.
- Push happens when `in_valid && in_ready && !flush`. The word and PC are written at `wr_ptr`, and `wr_ptr` increments.
- Pop happens when `out_valid && out_ready && !flush`. `rd_ptr` increments.
- When both push and pop occur in one cycle, `count` is unchanged. This is legal at any count from 1 to DEPTH-1.
- When full, `in_ready` is 0. A pop in that cycle does not open a slot until the next cycle; there is no pass-through.
- When empty, `out_valid` is 0 and `instr`/`pc` show NOP/0. There is no same-cycle bypass from input to output.
- `flush` has priority over everything else. At the next edge `rd_ptr`, `wr_ptr` and `count` return to 0. Any push or pop offered in the flush cycle is ignored. Array contents are not cleared.
- `in_valid` while `in_ready` is 0 is a stall, not an error; fetch must hold `next_instr`/`next_pc`.
- `out_ready` while empty has no effect.
- `instr`/`pc` are a combinational read of the array at `rd_ptr`, muxed to NOP/0 when empty. `in_ready`, `out_valid` and `count` are derived from `count` only.

## Timing
- Reset (`rst` low, asynchronous): `rd_ptr`=0, `wr_ptr`=0, `count`=0.
  - Outputs during reset: `in_ready`=1, `out_valid`=0, `instr`=NOP, `pc`=0.
  - Array contents are not reset.
- Deassertion of `rst` takes effect at the first following rising edge.
- Latency is one cycle. A word pushed at edge N appears on `instr` with `out_valid`=1 after edge N if the queue was empty.
- Throughput is one push and one pop per cycle, sustained, while 0 < `count` < DEPTH.
- `flush` is sampled at the edge. After that edge `out_valid`=0 and `in_ready`=1.
- An asynchronous reset mid-stream discards all entries. The first push after reset lands in entry 0.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 3 cycles with random inputs.
  - Required response: `in_ready`=1, `out_valid`=0, `instr`=0, `count`=0 throughout.
- Fill and drain (DEPTH=4, `out_ready`=0):
  - Stimulus: push 0x11111111..0x44444444 with PCs 0x0, 0x4, 0x8, 0xC.
  - Required response: `count` reaches 4 and `in_ready`=0. A 5th `in_valid` is not accepted.
  - Then set `out_ready`=1: `instr` shows 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles with matching PCs, then `out_valid`=0 and `instr`=0.
- Simultaneous push/pop and wrap:
  - Stimulus: pre-load 2 words, then push and pop every cycle for 10 cycles.
  - Required response: `count` stays 2, pointers wrap past 3 to 0, and output order equals input order.
- Full with pop:
  - Stimulus: at `count`=4, assert `in_valid` and `out_ready` together.
  - Required response: only the pop occurs, `count`=3 and the input is not taken. It is accepted on the next cycle and `count` returns to 4.
- Flush priority:
  - Stimulus: at `count`=3, assert `flush` together with `in_valid`=1 and `out_ready`=1.
  - Required response: after the edge `count`=0, `out_valid`=0, `instr`=0, and the offered word is dropped.
  - The next push appears as the head one cycle later.
- Async reset mid-operation:
  - Stimulus: pull `rst` low between edges with `count`=3.
  - Required response: `count`=0 and `out_valid`=0 immediately, without waiting for an edge. Normal operation resumes after release.
